// File: rtl/inst_encoder.sv
// RV64 field packer: encodes decoded fields into a 32-bit word, range-checks
// the immediate, and streams it with a fetch address through a 2-entry buffer.
module inst_encoder #(
  parameter int unsigned       ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [63:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [15:0]       err_count
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP_32  = 7'b0111011;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic w_u, w_j, w_i, w_s, w_b, w_r;
  logic w_sh64, w_sh32, w_shf;
  logic w_s12, w_s13, w_s21, w_s32;
  logic [31:0] w_enc;
  logic [31:0] w_inst;
  logic        w_bad;

  assign w_shf  = (in_funct3[1:0] == 2'b01);
  assign w_sh64 = (in_op == OP_IMM) && w_shf;
  assign w_sh32 = (in_op == OP_IMM_32) && w_shf;
  assign w_u = (in_op == OP_LUI) || (in_op == OP_AUIPC);
  assign w_j = (in_op == OP_JAL);
  assign w_i = !w_sh64 && !w_sh32 &&
    ((in_op == OP_JALR) || (in_op == OP_LOAD) ||
     (in_op == OP_IMM) || (in_op == OP_IMM_32) ||
     (in_op == OP_MISC) || (in_op == OP_SYSTEM));
  assign w_s = (in_op == OP_STORE);
  assign w_b = (in_op == OP_BRANCH);
  assign w_r = (in_op == OP_OP) || (in_op == OP_OP_32);

  // imm fits n-bit signed iff bits [63:n-1] are all equal
  assign w_s12 = (&in_imm[63:11]) || !(|in_imm[63:11]);
  assign w_s13 = (&in_imm[63:12]) || !(|in_imm[63:12]);
  assign w_s21 = (&in_imm[63:20]) || !(|in_imm[63:20]);
  assign w_s32 = (&in_imm[63:31]) || !(|in_imm[63:31]);

  always_comb begin
    w_enc = '0;
    w_bad = 1'b0;
    unique case (1'b1)
      w_u: begin
        w_enc = {in_imm[31:12], in_rd, in_op};
        w_bad = (in_imm[11:0] != 12'd0) || !w_s32;
      end
      w_j: begin
        w_enc = {in_imm[20], in_imm[10:1], in_imm[11],
                 in_imm[19:12], in_rd, in_op};
        w_bad = in_imm[0] || !w_s21;
      end
      w_sh64: begin
        w_enc = {in_funct7[6:1], in_imm[5:0], in_rs1,
                 in_funct3, in_rd, in_op};
        w_bad = (in_imm > 64'd63);
      end
      w_sh32: begin
        w_enc = {in_funct7, in_imm[4:0], in_rs1,
                 in_funct3, in_rd, in_op};
        w_bad = (in_imm > 64'd31);
      end
      w_i: begin
        w_enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_op};
        w_bad = !w_s12;
      end
      w_s: begin
        w_enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                 in_imm[4:0], in_op};
        w_bad = !w_s12;
      end
      w_b: begin
        w_enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1,
                 in_funct3, in_imm[4:1], in_imm[11], in_op};
        w_bad = in_imm[0] || !w_s13;
      end
      w_r: begin
        w_enc = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_op};
      end
      default: w_bad = 1'b1;
    endcase
  end

  assign w_inst = w_bad ? NOP : w_enc;

  logic [1:0][32:0]  r_buf;
  logic [1:0]        r_cnt;
  logic              r_rdy;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_errc;
  logic              w_push, w_pop;
  logic [1:0]        w_cnt_nxt, w_slot;

  assign w_push    = in_valid && r_rdy;
  assign w_pop     = (r_cnt != 2'd0) && out_ready;
  assign w_slot    = r_cnt - {1'b0, w_pop};
  assign w_cnt_nxt = r_cnt + {1'b0, w_push} - {1'b0, w_pop};

  // head lives in slot 0; a pop shifts slot 1 down before any push lands
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_buf  <= '0;
      r_cnt  <= 2'd0;
      r_rdy  <= 1'b1;
      r_addr <= BASE_ADDR;
      r_errc <= 16'd0;
    end else if (clear) begin
      r_cnt  <= 2'd0;
      r_rdy  <= 1'b1;
      r_addr <= BASE_ADDR;
      r_errc <= 16'd0;
    end else begin
      if (w_pop) begin
        r_buf[0] <= r_buf[1];
        r_addr   <= r_addr + ADDR_W'(4);
        if (r_buf[0][32] && (r_errc != 16'hFFFF))
          r_errc <= r_errc + 16'd1;
      end
      if (w_push)
        r_buf[w_slot[0]] <= {w_bad, w_inst};
      r_cnt <= w_cnt_nxt;
      r_rdy <= (w_cnt_nxt != 2'd2);
    end
  end

  assign in_ready  = r_rdy;
  assign out_valid = (r_cnt != 2'd0);
  assign out_inst  = r_buf[0][31:0];
  assign out_err   = r_buf[0][32];
  assign out_addr  = r_addr;
  assign err_count = r_errc;

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: directed vectors plus random traffic against a
// queue-based reference model of the encoding rules and stream behaviour.
module tb_inst_encoder;

  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam logic [3:0]  BASE2 = 4'd12;

  logic        clk = 1'b0;
  logic        reset_n, clear, in_valid, out_ready;
  logic [6:0]  in_op, in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [63:0] in_imm;
  logic        in_ready, out_valid, out_err;
  logic [31:0] out_inst;
  logic [63:0] out_addr;
  logic [15:0] err_count;
  logic        o2_in_ready, o2_valid, o2_err;
  logic [31:0] o2_inst;
  logic [3:0]  o2_addr;
  logic [15:0] o2_errc;

  always #5 clk = ~clk;

  inst_encoder #(.ADDR_W(64), .BASE_ADDR(BASE)) u_dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr),
    .out_err(out_err), .err_count(err_count)
  );

  inst_encoder #(.ADDR_W(4), .BASE_ADDR(BASE2)) u_w4 (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .in_valid(in_valid), .in_ready(o2_in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(o2_valid), .out_ready(out_ready),
    .out_inst(o2_inst), .out_addr(o2_addr),
    .out_err(o2_err), .err_count(o2_errc)
  );

  typedef struct {
    logic [31:0] inst;
    logic        err;
  } ent_t;

  ent_t        m_q[$];
  logic [63:0] m_addr;
  logic [3:0]  m_addr2;
  logic [15:0] m_errc;
  bit          m_pushed;
  int          n_pass = 0;
  int          n_tot  = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic longint bits(longint x, int lo, int n);
    return (x >> lo) & ((longint'(1) << n) - 1);
  endfunction

  function automatic bit rng(longint v, int n);
    longint lim = longint'(1) << (n - 1);
    return (v >= -lim) && (v < lim);
  endfunction

  function automatic ent_t ref_enc(logic [6:0] op, logic [4:0] rd,
      logic [4:0] rs1, logic [4:0] rs2, logic [2:0] f3,
      logic [6:0] f7, logic [63:0] imm);
    longint v, w, o, d, s1, s2, f, g;
    longint unsigned u;
    bit e;
    ent_t r;
    v = longint'(imm); u = imm;
    o = longint'(op); d = longint'(rd); f = longint'(f3);
    s1 = longint'(rs1); s2 = longint'(rs2); g = longint'(f7);
    e = 0; w = 0;
    if ((op == 7'h13 || op == 7'h1B) && (f3 == 3'd1 || f3 == 3'd5)) begin
      if (op == 7'h13) begin
        e = u > 63;
        w = ((g >> 1) << 26) | ((u & 63) << 20);
      end else begin
        e = u > 31;
        w = (g << 25) | ((u & 31) << 20);
      end
      w = w | (s1 << 15) | (f << 12) | (d << 7) | o;
    end else begin
      case (op)
        7'h37, 7'h17: begin
          e = !rng(v, 32) || bits(v, 0, 12) != 0;
          w = (bits(v, 12, 20) << 12) | (d << 7) | o;
        end
        7'h6F: begin
          e = !rng(v, 21) || bits(v, 0, 1) != 0;
          w = (bits(v, 20, 1) << 31) | (bits(v, 1, 10) << 21)
            | (bits(v, 11, 1) << 20) | (bits(v, 12, 8) << 12)
            | (d << 7) | o;
        end
        7'h67, 7'h03, 7'h13, 7'h1B, 7'h0F, 7'h73: begin
          e = !rng(v, 12);
          w = (bits(v, 0, 12) << 20) | (s1 << 15) | (f << 12)
            | (d << 7) | o;
        end
        7'h23: begin
          e = !rng(v, 12);
          w = (bits(v, 5, 7) << 25) | (s2 << 20) | (s1 << 15)
            | (f << 12) | (bits(v, 0, 5) << 7) | o;
        end
        7'h63: begin
          e = !rng(v, 13) || bits(v, 0, 1) != 0;
          w = (bits(v, 12, 1) << 31) | (bits(v, 5, 6) << 25)
            | (s2 << 20) | (s1 << 15) | (f << 12)
            | (bits(v, 1, 4) << 8) | (bits(v, 11, 1) << 7) | o;
        end
        7'h33, 7'h3B: begin
          w = (g << 25) | (s2 << 20) | (s1 << 15) | (f << 12)
            | (d << 7) | o;
        end
        default: e = 1;
      endcase
    end
    r.err  = e;
    r.inst = e ? 32'h13 : w[31:0];
    return r;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_addr  = BASE;
    m_addr2 = BASE2;
    m_errc  = 16'd0;
  endtask

  task automatic chk_state();
    chk("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
    chk("in_ready", 64'(in_ready), 64'(m_q.size() < 2));
    chk("out_addr", out_addr, m_addr);
    chk("addr_w4", 64'(o2_addr), 64'(m_addr2));
    chk("err_count", 64'(err_count), 64'(m_errc));
    if (m_q.size() != 0) begin
      chk("out_inst", 64'(out_inst), 64'(m_q[0].inst));
      chk("out_err", 64'(out_err), 64'(m_q[0].err));
    end
  endtask

  task automatic tick();
    bit   push, pop;
    ent_t e, w;
    push = in_valid && (m_q.size() < 2);
    pop  = out_ready && (m_q.size() > 0);
    e = ref_enc(in_op, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
    @(posedge clk);
    m_pushed = 0;
    if (clear) begin
      model_reset();
    end else begin
      if (pop) begin
        w = m_q.pop_front();
        m_addr  = m_addr + 64'd4;
        m_addr2 = m_addr2 + 4'd4;
        if (w.err && m_errc != 16'hFFFF) m_errc = m_errc + 16'd1;
      end
      if (push) begin
        m_q.push_back(e);
        m_pushed = 1;
      end
    end
    #1;
    chk_state();
  endtask

  task automatic drive(input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [2:0] f3, input logic [6:0] f7,
      input logic [63:0] imm);
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1;
    in_rs2 = rs2; in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  function automatic logic [63:0] rand_imm();
    longint t[20] = '{2047, 2048, -2048, -2049, 4095, 4096, -4096,
      -4097, 1048575, 1048576, -1048576, 64'h7FFF_F000,
      64'h8000_0000, -64'sh8000_0000, 63, 64, 31, 32, 1, 3};
    logic [63:0] r;
    case ($urandom_range(0, 4))
      0: r = 64'(longint'($urandom_range(0, 128)) - 64);
      1: r = 64'(t[$urandom_range(0, 19)]);
      2: r = {$urandom, $urandom};
      3: r = {{52{1'b0}}, 12'($urandom)} ^
             (($urandom_range(0, 1) != 0) ? 64'hFFFF_FFFF_FFFF_F000 : 64'd0);
      default: r = {{32{1'b0}}, $urandom & 32'hFFFF_F000};
    endcase
    return r;
  endfunction

  task automatic drive_rand();
    logic [6:0] ops[13] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03,
      7'h13, 7'h1B, 7'h0F, 7'h73, 7'h23, 7'h63, 7'h33, 7'h3B};
    logic [6:0] op;
    op = ($urandom_range(0, 9) == 0) ? 7'($urandom)
                                     : ops[$urandom_range(0, 12)];
    drive(op, 5'($urandom), 5'($urandom), 5'($urandom),
          3'($urandom), 7'($urandom), rand_imm());
  endtask

  initial begin
    logic [6:0] bp_rd[3] = '{7'd3, 7'd4, 7'd5};
    int sent;
    reset_n = 1'b0; clear = 1'b0; out_ready = 1'b1;
    drive(7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd0);
    in_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_inst", 64'(out_inst), 64'd0);
    chk("rst_err", 64'(out_err), 64'd0);
    chk("rst_addr", out_addr, BASE);
    chk("rst_errc", 64'(err_count), 64'd0);
    reset_n = 1'b1;
    tick();

    drive(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    tick(); in_valid = 1'b0;
    chk("addi_inst", 64'(out_inst), 64'hFFF0_0093);
    chk("addi_addr", out_addr, BASE);
    tick();
    chk("wrap_w4", 64'(o2_addr), 64'd0);

    drive(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd2048);
    tick(); in_valid = 1'b0;
    chk("jal_inst", 64'(out_inst), 64'h0010_00EF);
    tick();
    drive(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -64'sd4);
    tick(); in_valid = 1'b0;
    chk("beq_inst", 64'(out_inst), 64'hFE20_8EE3);
    tick();
    drive(7'h23, 5'd0, 5'd1, 5'd2, 3'd3, 7'd0, 64'd8);
    tick(); in_valid = 1'b0;
    chk("sd_inst", 64'(out_inst), 64'h0020_B423);
    tick();

    drive(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd2048);
    tick(); in_valid = 1'b0;
    chk("addi_err", 64'(out_err), 64'd1);
    chk("addi_nop", 64'(out_inst), 64'h13);
    tick();
    chk("errc_1", 64'(err_count), 64'd1);
    drive(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 64'd3);
    tick(); in_valid = 1'b0;
    chk("beq_err", 64'(out_err), 64'd1);
    tick();
    drive(7'h13, 5'd1, 5'd1, 5'd0, 3'd1, 7'd0, 64'd64);
    tick(); in_valid = 1'b0;
    chk("slli_err", 64'(out_err), 64'd1);
    tick();
    chk("errc_3", 64'(err_count), 64'd3);

    out_ready = 1'b0;
    sent = 0;
    drive(7'h33, 5'(bp_rd[0]), 5'd1, 5'd2, 3'd0, 7'd0, 64'd0);
    for (int c = 0; c < 10; c++) begin
      if (c == 4) begin
        chk("bp_ready", 64'(in_ready), 64'd0);
        chk("bp_held", 64'(sent), 64'd2);
        out_ready = 1'b1;
      end
      tick();
      if (m_pushed) begin
        sent++;
        if (sent < 3)
          drive(7'h33, 5'(bp_rd[sent]), 5'd1, 5'd2, 3'd0, 7'd0, 64'd0);
        else
          in_valid = 1'b0;
      end
    end
    chk("bp_sent", 64'(sent), 64'd3);

    out_ready = 1'b0;
    drive(7'h33, 5'd6, 5'd1, 5'd2, 3'd0, 7'd0, 64'd0);
    tick(); tick();
    clear = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    chk("clr_valid", 64'(out_valid), 64'd0);
    chk("clr_ready", 64'(in_ready), 64'd1);
    chk("clr_addr", out_addr, BASE);
    out_ready = 1'b1;

    for (int k = 0; k < 400; k++) begin
      clear = ($urandom_range(0, 49) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0) drive_rand();
      else in_valid = 1'b0;
      tick();
    end
    clear = 1'b0;

    out_ready = 1'b0;
    drive(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 64'd5000);
    tick(); tick();
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_ready", 64'(in_ready), 64'd1);
    chk("arst_inst", 64'(out_inst), 64'd0);
    chk("arst_err", 64'(out_err), 64'd0);
    chk("arst_addr", out_addr, BASE);
    chk("arst_errc", 64'(err_count), 64'd0);
    model_reset();
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 1) != 0) drive_rand();
      else in_valid = 1'b0;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
